// File: rtl/addsub_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_sequencer_pkg : state and opcode encodings for the sequencer |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package addsub_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/addsub_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_sequencer_if : operand bus, adder link and result flags      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface addsub_sequencer_if #(
  parameter int W = 4
);
  logic [W-1:0] din;
  logic         load_a;
  logic         load_b;
  logic         op;
  logic         go;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_ci;
  logic [W-1:0] add_s;
  logic         add_co;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;
  logic         busy;
  logic         done;

  // Sequencer side
  modport slave (
    input  din, load_a, load_b, op, go, add_s, add_co,
    output add_a, add_b, add_ci, result, carry, ovf, zero, busy, done
  );

  // Environment side: operand source plus the external adder
  modport master (
    output din, load_a, load_b, op, go, add_s, add_co,
    input  add_a, add_b, add_ci, result, carry, ovf, zero, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/addsub_sequencer_flags.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_flags : combinational zero and two's-complement overflow     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module addsub_flags #(
  parameter int W = 4
) (
  input  wire logic         a_msb_i,
  input  wire logic         b_msb_i,
  input  wire logic [W-1:0] s_i,
  output logic              zero_o,
  output logic              ovf_o
);
  import addsub_sequencer_pkg::*;

  // b_msb_i is the MSB after the subtract inversion, so one rule covers add and sub
  assign zero_o = (s_i == '0);
  assign ovf_o  = (a_msb_i == b_msb_i) && (s_i[W-1] != a_msb_i);

endmodule
`default_nettype wire

// File: rtl/addsub_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_sequencer : operand capture and add/sub control for an       |
// | external ripple adder; registers result and flags. Revision 1.0    |
// +--------------------------------------------------------------------+
module addsub_sequencer #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  addsub_sequencer_if.slave bus
);
  import addsub_sequencer_pkg::*;

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         op_q, op_d;
  logic         a_vld_q, a_vld_d;
  logic         b_vld_q, b_vld_d;
  logic [W-1:0] result_q, result_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;
  logic         zero_q, zero_d;
  logic         done_q, done_d;

  logic [W-1:0] w_add_b;
  logic         w_zero;
  logic         w_ovf;

  assign w_add_b    = b_q ^ {W{op_q}};
  assign bus.add_a  = a_q;
  assign bus.add_b  = w_add_b;
  assign bus.add_ci = (op_q == OP_SUB);

  addsub_flags #(.W(W)) u_flags (
    .a_msb_i (a_q[W-1]),
    .b_msb_i (w_add_b[W-1]),
    .s_i     (bus.add_s),
    .zero_o  (w_zero),
    .ovf_o   (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    a_vld_d  = a_vld_q;
    b_vld_d  = b_vld_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_a) begin
          a_d     = bus.din;
          a_vld_d = 1'b1;
        end
        if (bus.load_b) begin
          b_d     = bus.din;
          b_vld_d = 1'b1;
        end
        // go qualifies on the flags held before this cycle's loads
        if (bus.go && a_vld_q && b_vld_q) begin
          op_d    = bus.op;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        result_d = bus.add_s;
        carry_d  = bus.add_co;
        zero_d   = w_zero;
        ovf_d    = w_ovf;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == EXEC) || (state_q == CAPT);

endmodule
`default_nettype wire
